// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: opcodes, select codes,
// ALU function codes and the per-stage control words.
package mips_ctrl_pkg;

  localparam logic [4:0] XP_REG = 5'd26;
  localparam logic [4:0] RA_REG = 5'd31;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JR     = 3'd3,
    PC_ILLOP  = 3'd4,
    PC_XADR   = 3'd5
  } pcsrc_e;

  typedef enum logic [1:0] {
    DST_RD = 2'd0,
    DST_RT = 2'd1,
    DST_RA = 2'd2,
    DST_XP = 2'd3
  } regdst_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } memtoreg_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_e;

  // Nested so each pipeline register holds exactly what its later stages consume.
  typedef struct packed {
    regdst_e   regdst;
    memtoreg_e memtoreg;
    logic      regwrite;
  } wb_ctrl_t;

  typedef struct packed {
    logic     memread;
    logic     memwrite;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic      alusrc1;
    logic      alusrc2;
    alu_e      aluop;
    mem_ctrl_t mem;
  } pipe_ctrl_t;

  typedef struct packed {
    pcsrc_e     pcsrc;
    logic       extop;
    logic       luop;
    logic       is_branch;
    logic       illegal;
    pipe_ctrl_t pipe;
  } dec_t;

  localparam wb_ctrl_t WB_BUBBLE = '{regdst: DST_RD, memtoreg: WB_ALU, regwrite: 1'b0};
  localparam wb_ctrl_t WB_TRAP   = '{regdst: DST_XP, memtoreg: WB_PC4, regwrite: 1'b1};

  localparam mem_ctrl_t MEM_BUBBLE = '{memread: 1'b0, memwrite: 1'b0, wb: WB_BUBBLE};

  localparam pipe_ctrl_t PIPE_BUBBLE = '{alusrc1: 1'b0, alusrc2: 1'b0, aluop: ALU_ADD,
                                         mem: MEM_BUBBLE};
  localparam pipe_ctrl_t PIPE_TRAP   = '{alusrc1: 1'b0, alusrc2: 1'b0, aluop: ALU_ADD,
                                         mem: '{memread: 1'b0, memwrite: 1'b0, wb: WB_TRAP}};

  localparam dec_t DEC_NOP = '{pcsrc: PC_PLUS4, extop: 1'b0, luop: 1'b0, is_branch: 1'b0,
                               illegal: 1'b0, pipe: PIPE_BUBBLE};
  localparam dec_t DEC_ILLEGAL = '{pcsrc: PC_PLUS4, extop: 1'b0, luop: 1'b0, is_branch: 1'b0,
                                   illegal: 1'b1, pipe: PIPE_BUBBLE};

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction -> control word decode; no gating by
// valid/stall/flush, which is applied by the caller.
module control_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_fields;
  dec_t       d;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign rt            = instr_i[20:16];
  assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};
  assign dec_o         = d;

  // Opcode/funct decode into selects and the control word carried down the pipe.
  always_comb begin
    d = DEC_NOP;
    case (opcode)
      OP_RTYPE: begin
        d.pipe.mem.wb.regwrite = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: d.pipe.aluop = ALU_ADD;
          FN_SUB, FN_SUBU: d.pipe.aluop = ALU_SUB;
          FN_AND:  d.pipe.aluop = ALU_AND;
          FN_OR:   d.pipe.aluop = ALU_OR;
          FN_XOR:  d.pipe.aluop = ALU_XOR;
          FN_NOR:  d.pipe.aluop = ALU_NOR;
          FN_SLT:  d.pipe.aluop = ALU_SLT;
          FN_SLTU: d.pipe.aluop = ALU_SLTU;
          FN_SLL: begin
            d.pipe.alusrc1 = 1'b1;
            d.pipe.aluop   = ALU_SLL;
          end
          FN_SRL: begin
            d.pipe.alusrc1 = 1'b1;
            d.pipe.aluop   = ALU_SRL;
          end
          FN_SRA: begin
            d.pipe.alusrc1 = 1'b1;
            d.pipe.aluop   = ALU_SRA;
          end
          FN_JR: begin
            d.pcsrc                = PC_JR;
            d.pipe.mem.wb.regwrite = 1'b0;
          end
          FN_JALR: begin
            d.pcsrc                = PC_JR;
            d.pipe.mem.wb.memtoreg = WB_PC4;
          end
          default: d = DEC_ILLEGAL;
        endcase
      end
      // Only bltz (rt == 0) is supported out of the REGIMM group.
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          d.is_branch   = 1'b1;
          d.extop       = 1'b1;
          d.pipe.aluop  = ALU_SUB;
        end else begin
          d = DEC_ILLEGAL;
        end
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        d.is_branch  = 1'b1;
        d.extop      = 1'b1;
        d.pipe.aluop = ALU_SUB;
      end
      OP_J: d.pcsrc = PC_JUMP;
      OP_JAL: begin
        d.pcsrc       = PC_JUMP;
        d.pipe.mem.wb = '{regdst: DST_RA, memtoreg: WB_PC4, regwrite: 1'b1};
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI: begin
        d.extop        = (opcode != OP_ANDI);
        d.pipe.alusrc2 = 1'b1;
        d.pipe.mem.wb  = '{regdst: DST_RT, memtoreg: WB_ALU, regwrite: 1'b1};
        case (opcode)
          OP_SLTI:  d.pipe.aluop = ALU_SLT;
          OP_SLTIU: d.pipe.aluop = ALU_SLTU;
          OP_ANDI:  d.pipe.aluop = ALU_AND;
          default:  d.pipe.aluop = ALU_ADD;
        endcase
      end
      OP_LUI: begin
        d.luop         = 1'b1;
        d.pipe.alusrc2 = 1'b1;
        d.pipe.mem.wb  = '{regdst: DST_RT, memtoreg: WB_ALU, regwrite: 1'b1};
      end
      OP_LW: begin
        d.extop               = 1'b1;
        d.pipe.alusrc2        = 1'b1;
        d.pipe.mem.memread    = 1'b1;
        d.pipe.mem.wb         = '{regdst: DST_RT, memtoreg: WB_MEM, regwrite: 1'b1};
      end
      OP_SW: begin
        d.extop             = 1'b1;
        d.pipe.alusrc2      = 1'b1;
        d.pipe.mem.memwrite = 1'b1;
      end
      default: d = DEC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// ID-stage control decode plus ID/EX, EX/MEM, MEM/WB control registers,
// bubble insertion on stall/flush, illegal-op trap and interrupt latching.
module pipeline_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        id_valid,
  input  logic        branch_taken,
  input  logic        stall,
  input  logic        flush,
  input  logic        irq,
  input  logic        kernel_mode,
  output logic [2:0]  PCSrc,
  output logic        EXTOp,
  output logic        LUOp,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [3:0]  ALUOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemToReg,
  output logic        RegWrite,
  output logic        irq_ack
);

  dec_t       dec;
  pcsrc_e     pcsrc;
  pipe_ctrl_t idex_d, idex_q;
  mem_ctrl_t  exmem_q;
  wb_ctrl_t   memwb_q;
  logic       irq_pend_d, irq_pend_q;
  logic       id_live;
  logic       take_irq;
  logic       take_ill;

  control_decode u_decode (
    .instr_i (instruction),
    .dec_o   (dec)
  );

  // An ID instruction may only act when it is real, not held and not killed.
  assign id_live  = id_valid & ~stall & ~flush & ~reset;
  assign take_irq = id_live & (irq | irq_pend_q) & ~kernel_mode;
  assign take_ill = id_live & dec.illegal & ~take_irq;

  // PC select, ID/EX entry word and interrupt-pending update.
  always_comb begin
    pcsrc      = PC_PLUS4;
    idex_d     = PIPE_BUBBLE;
    irq_pend_d = irq_pend_q | irq;
    if (take_irq) begin
      pcsrc      = PC_XADR;
      idex_d     = PIPE_TRAP;
      irq_pend_d = 1'b0;
    end else if (take_ill) begin
      pcsrc  = PC_ILLOP;
      idex_d = PIPE_TRAP;
    end else if (id_live) begin
      idex_d = dec.pipe;
      if (dec.is_branch) begin
        pcsrc = branch_taken ? PC_BRANCH : PC_PLUS4;
      end else begin
        pcsrc = dec.pcsrc;
      end
    end else begin
      pcsrc = PC_PLUS4;
    end
  end

  // Stage control registers; reset drops every in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q     <= PIPE_BUBBLE;
      exmem_q    <= MEM_BUBBLE;
      memwb_q    <= WB_BUBBLE;
      irq_pend_q <= 1'b0;
    end else begin
      idex_q     <= idex_d;
      exmem_q    <= idex_q.mem;
      memwb_q    <= exmem_q.wb;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign PCSrc    = pcsrc;
  assign EXTOp    = dec.extop & ~reset;
  assign LUOp     = dec.luop & ~reset;
  assign irq_ack  = take_irq;
  assign ALUSrc1  = idex_q.alusrc1;
  assign ALUSrc2  = idex_q.alusrc2;
  assign ALUOp    = idex_q.aluop;
  assign MemRead  = exmem_q.memread;
  assign MemWrite = exmem_q.memwrite;
  assign RegDst   = memwb_q.regdst;
  assign MemToReg = memwb_q.memtoreg;
  assign RegWrite = memwb_q.regwrite;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench: stimulus pushes hand-computed expectations tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_pipeline_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        id_valid = 1'b0, branch_taken = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        irq = 1'b0, kernel_mode = 1'b0;
  logic [2:0]  PCSrc;
  logic        EXTOp, LUOp, ALUSrc1, ALUSrc2, MemRead, MemWrite, RegWrite, irq_ack;
  logic [3:0]  ALUOp;
  logic [1:0]  RegDst, MemToReg;

  pipeline_control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .id_valid(id_valid),
    .branch_taken(branch_taken), .stall(stall), .flush(flush), .irq(irq),
    .kernel_mode(kernel_mode), .PCSrc(PCSrc), .EXTOp(EXTOp), .LUOp(LUOp),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_PC = 0, S_EXT = 1, S_LU = 2, S_SRC1 = 3, S_SRC2 = 4, S_ALU = 5,
                 S_MRD = 6, S_MWR = 7, S_DST = 8, S_M2R = 9, S_RW = 10, S_ACK = 11;
  string names [12] = '{"PCSrc", "EXTOp", "LUOp", "ALUSrc1", "ALUSrc2", "ALUOp",
                        "MemRead", "MemWrite", "RegDst", "MemToReg", "RegWrite", "irq_ack"};

  localparam logic [31:0] I_ADDI = 32'h20E30005;  // addi $3,$7,5
  localparam logic [31:0] I_LW   = 32'h8C220000;  // lw   $2,0($1)
  localparam logic [31:0] I_SW   = 32'hAC220004;  // sw   $2,4($1)
  localparam logic [31:0] I_BEQ  = 32'h10220002;  // beq  $1,$2,8
  localparam logic [31:0] I_SLL  = 32'h00052080;  // sll  $4,$5,2
  localparam logic [31:0] I_ANDI = 32'h308300FF;  // andi $3,$4,0xff
  localparam logic [31:0] I_LUI  = 32'h3C051234;  // lui  $5,0x1234
  localparam logic [31:0] I_JAL  = 32'h0C000040;
  localparam logic [31:0] I_JR   = 32'h03E00008;  // jr   $31
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [31:0] dut_val(int s);
    case (s)
      S_PC:    return {29'd0, PCSrc};
      S_EXT:   return {31'd0, EXTOp};
      S_LU:    return {31'd0, LUOp};
      S_SRC1:  return {31'd0, ALUSrc1};
      S_SRC2:  return {31'd0, ALUSrc2};
      S_ALU:   return {28'd0, ALUOp};
      S_MRD:   return {31'd0, MemRead};
      S_MWR:   return {31'd0, MemWrite};
      S_DST:   return {30'd0, RegDst};
      S_M2R:   return {30'd0, MemToReg};
      S_RW:    return {31'd0, RegWrite};
      S_ACK:   return {31'd0, irq_ack};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(int dly, int s, logic [31:0] v);
    exp_t e;
    e.due = cyc + dly;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_zero(int dly);
    for (int s = 0; s < 12; s++) expect_at(dly, s, 32'd0);
  endtask

  task automatic step(logic [31:0] ins, logic v, logic bt, logic st, logic fl,
                      logic iq, logic km, logic rs);
    @(posedge clk);
    #1;
    instruction  = ins;
    id_valid     = v;
    branch_taken = bt;
    stall        = st;
    flush        = fl;
    irq          = iq;
    kernel_mode  = km;
    reset        = rs;
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        total++;
        if (dut_val(sb[i].sig) !== sb[i].exp) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%0d exp=%0d", names[sb[i].sig], cyc,
                   dut_val(sb[i].sig), sb[i].exp);
        end
      end else if (sb[i].due < cyc) begin
        total++;
        bad++;
        $display("FAIL stale_%s due=%0d cyc=%0d got=none exp=%0d", names[sb[i].sig],
                 sb[i].due, cyc, sb[i].exp);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  initial begin
    // Reset: everything zero even with a taken branch presented.
    step(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_zero(0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_zero(0);

    // addi
    step(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 0); expect_at(0, S_EXT, 1); expect_at(0, S_LU, 0); expect_at(0, S_ACK, 0);
    expect_at(1, S_SRC2, 1); expect_at(1, S_SRC1, 0); expect_at(1, S_ALU, 0);
    expect_at(2, S_MRD, 0); expect_at(2, S_MWR, 0);
    expect_at(3, S_DST, 1); expect_at(3, S_M2R, 0); expect_at(3, S_RW, 1);

    // lw followed by a load-use stall
    step(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_EXT, 1); expect_at(1, S_SRC2, 1);
    expect_at(2, S_MRD, 1); expect_at(3, S_M2R, 1); expect_at(3, S_DST, 1); expect_at(3, S_RW, 1);
    step(I_ADDI, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 0);
    expect_at(1, S_SRC1, 0); expect_at(1, S_SRC2, 0); expect_at(1, S_ALU, 0);
    expect_at(2, S_MRD, 0); expect_at(3, S_RW, 0);
    step(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(1, S_SRC2, 1); expect_at(3, S_RW, 1);

    // sll / andi / lui
    step(I_SLL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_EXT, 0); expect_at(1, S_SRC1, 1); expect_at(1, S_SRC2, 0); expect_at(1, S_ALU, 8);
    expect_at(3, S_DST, 0); expect_at(3, S_RW, 1);
    step(I_ANDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_EXT, 0); expect_at(1, S_ALU, 2); expect_at(1, S_SRC2, 1);
    step(I_LUI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_LU, 1); expect_at(1, S_SRC2, 1); expect_at(3, S_DST, 1);

    // beq taken / not taken, jal, jr, flushed jal
    step(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 1); expect_at(0, S_EXT, 1); expect_at(2, S_MWR, 0); expect_at(3, S_RW, 0);
    step(I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 0); expect_at(3, S_RW, 0);
    step(I_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 2); expect_at(3, S_DST, 2); expect_at(3, S_M2R, 2); expect_at(3, S_RW, 1);
    step(I_JR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 3); expect_at(3, S_RW, 0);
    step(I_JAL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 0); expect_at(3, S_RW, 0); expect_at(3, S_M2R, 0);

    // irq pulse during stall, taken the following cycle
    step(I_ADDI, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_at(0, S_PC, 0); expect_at(0, S_ACK, 0); expect_at(3, S_RW, 0);
    step(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 5); expect_at(0, S_ACK, 1); expect_at(1, S_SRC2, 0);
    expect_at(2, S_MRD, 0); expect_at(2, S_MWR, 0);
    expect_at(3, S_DST, 3); expect_at(3, S_M2R, 2); expect_at(3, S_RW, 1);
    step(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 0); expect_at(0, S_ACK, 0); expect_at(3, S_DST, 1);

    // illegal op, then illegal op with irq (interrupt wins)
    step(I_ILL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 4); expect_at(0, S_ACK, 0);
    expect_at(3, S_DST, 3); expect_at(3, S_M2R, 2); expect_at(3, S_RW, 1);
    step(I_ILL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_at(0, S_PC, 5); expect_at(0, S_ACK, 1); expect_at(3, S_DST, 3);

    // irq masked in kernel mode stays pending across an empty ID slot
    step(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_at(0, S_PC, 0); expect_at(0, S_ACK, 0); expect_at(3, S_DST, 1);
    step(I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 0); expect_at(0, S_ACK, 0); expect_at(3, S_RW, 0);
    step(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_PC, 5); expect_at(0, S_ACK, 1); expect_at(3, S_DST, 3);
    for (int k = 0; k < 3; k++) step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset while sw is in EX discards it
    step(I_SW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(0, S_EXT, 1); expect_at(1, S_SRC2, 1);
    step(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(0, S_PC, 0); expect_at(0, S_EXT, 0); expect_at(0, S_ACK, 0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_zero(0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_zero(0);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      total += sb.size();
      bad += sb.size();
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Producer side of the datapath select buses. Decodes the ID-stage instruction into the PCSrc/RegDst/ALUSrc1/ALUSrc2/MemToReg/EXTOp/LUOp selects consumed by the datapath muxes, plus ALU and memory controls. Carries each group down ID/EX, EX/MEM and MEM/WB control registers so every select appears in the stage that uses it. Owns stall/flush bubble insertion, illegal-op trapping and interrupt latching.

Parameters:
XP_REG, 5'd26, register written with return address on trap/interrupt
RA_REG, 5'd31, register written by jal/jalr

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
instruction  in  32  ID-stage instruction
id_valid  in  1  ID holds a real instruction
branch_taken  in  1  ID comparator result for current branch
stall  in  1  load-use hazard; insert bubble into EX
flush  in  1  kill ID instruction (taken branch/jump behind)
irq  in  1  external interrupt request, level
kernel_mode  in  1  PC[31]; interrupts masked when 1
PCSrc  out  3  ID: 0 PC+4, 1 branch, 2 jump, 3 jr reg, 4 ILLOP, 5 XADR
EXTOp  out  1  ID: 1 sign-extend imm16
LUOp  out  1  ID: 1 imm16<<16
ALUSrc1  out  1  EX: 0 DataBusA, 1 shamt
ALUSrc2  out  1  EX: 0 DataBusB, 1 extended imm
ALUOp  out  4  EX: ALU function code
MemRead  out  1  MEM
MemWrite  out  1  MEM
RegDst  out  2  WB: 0 rd, 1 rt, 2 RA_REG, 3 XP_REG
MemToReg  out  2  WB: 0 ALUOUT, 1 ReadData, 2 PC+4
RegWrite  out  1  WB
irq_ack  out  1  ID: interrupt taken this cycle

Behaviour:
- Supported: R-type add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/jr/jalr; lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, bltz, j, jal. Anything else = illegal.
- ID outputs combinational from instruction, same cycle. EX outputs 1 cycle after ID, MEM 2, WB 3.
- PCSrc=1 only for a branch with branch_taken=1; else 0. j/jal 2; jr/jalr 3.
- andi: EXTOp=0; other imm ops and lw/sw/branches: EXTOp=1. lui: LUOp=1, ALUSrc2=1.
- Shifts sll/srl/sra: ALUSrc1=1. jal/jalr: MemToReg=2, RegWrite=1, RegDst=2 (jal) / 0 (jalr).
- Bubble = all control zero (RegWrite=MemRead=MemWrite=0, selects 0).
- irq_pend register: set on irq=1, cleared when taken.
- Take interrupt when (irq|irq_pend) & id_valid & !stall & !flush & !kernel_mode: PCSrc=5, irq_ack=1, pipeline entry RegDst=3, MemToReg=2, RegWrite=1, no mem access.
- Illegal op with id_valid and no interrupt: PCSrc=4, same trap entry as interrupt. Interrupt beats illegal op.
- stall=1: ID/EX loads bubble; EX/MEM and MEM/WB advance; PCSrc forced 0; interrupt not taken, pend kept.
- flush=1 (alone or with stall): ID/EX loads bubble; PCSrc=0; pend kept.
- id_valid=0: ID/EX bubble; PCSrc=0.
- reset=1: all stage registers bubble, irq_pend=0, ID outputs 0, irq_ack=0; mid-operation reset discards in-flight instructions at next edge.

Decomposition:
- Package mips_ctrl_pkg: opcode/funct constants, PCSrc/RegDst/MemToReg encodings, ALUOp codes, bubble constant.
- Sub-module control_decode: purely combinational instruction->control-word decode; top holds irq_pend, stage registers, stall/flush muxing.

Test Plan:
- addi $3,$7,5 (0x20E30005), id_valid=1 -> same cycle EXTOp=1, PCSrc=0; +1 ALUSrc2=1; +3 RegDst=1, MemToReg=0, RegWrite=1.
- lw then stall=1 one cycle -> +1 after stall EX controls all 0; MEM/WB of lw continue: MemRead=1 at +2 from lw, MemToReg=1 at +3.
- beq with branch_taken=1 -> PCSrc=1; branch_taken=0 -> PCSrc=0; RegWrite never 1 for it.
- irq pulse 1 cycle while stall=1, next cycle stall=0 -> irq_ack=1, PCSrc=5 then; +3 RegDst=3, MemToReg=2, RegWrite=1; irq_pend cleared.
- opcode 6'b111111 -> PCSrc=4; with irq=1, kernel_mode=0 simultaneously -> PCSrc=5.
- reset asserted while sw in EX -> next cycle MemWrite=0, RegWrite=0, all outputs 0.
